// File: rtl/pdm_serializer.sv
// PDM transmit serializer: double-buffered words are shifted out MSB-first on a
// self-generated bit clock. An idle 1010 pattern is sent whenever no word is available.
module pdm_serializer #(
  parameter int WORD_LENGTH        = 16,
  parameter int SYSTEM_FREQUENCY   = 100000000,
  parameter int SAMPLING_FREQUENCY = 1000000
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,
  input  logic                   enable_i,
  input  logic [WORD_LENGTH-1:0] data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic                   word_done_o,
  output logic                   underrun_o,
  input  logic                   clear_i,
  output logic                   pdm_clk_o,
  output logic                   pdm_data_o,
  output logic                   audio_sd_o
);

  localparam int HALF = (SYSTEM_FREQUENCY / SAMPLING_FREQUENCY) / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BW   = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(HALF - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(WORD_LENGTH - 1);

  logic [CW-1:0]          count;
  logic [BW-1:0]          bits_left;
  logic [WORD_LENGTH-1:0] hold;
  logic [WORD_LENGTH-1:0] shifter;
  logic                   hold_full;
  logic                   started;
  logic                   idle_phase;
  logic                   pdm_clk;
  logic                   pdm_data;
  logic                   word_done;
  logic                   underrun;
  logic                   audio_sd;

  logic tick;
  logic bit_event;
  logic accept;
  logic starve;

  // Bit events happen on the falling edge of the bit clock, so data is centred on rising edges.
  assign tick      = enable_i && (count == LAST_COUNT);
  assign bit_event = tick && pdm_clk;
  assign ready_o   = enable_i & ~hold_full;
  assign accept    = valid_i & ready_o;
  assign starve    = bit_event && (bits_left == '0) && !hold_full;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count      <= '0;
      bits_left  <= '0;
      hold       <= '0;
      shifter    <= '0;
      hold_full  <= 1'b0;
      started    <= 1'b0;
      idle_phase <= 1'b0;
      pdm_clk    <= 1'b0;
      pdm_data   <= 1'b0;
      word_done  <= 1'b0;
      underrun   <= 1'b0;
      audio_sd   <= 1'b0;
    end else if (!enable_i) begin
      // Disabling discards any buffered word; only the sticky underrun flag survives.
      count      <= '0;
      bits_left  <= '0;
      hold_full  <= 1'b0;
      started    <= 1'b0;
      idle_phase <= 1'b0;
      pdm_clk    <= 1'b0;
      pdm_data   <= 1'b0;
      word_done  <= 1'b0;
      audio_sd   <= 1'b0;
      if (clear_i) begin
        underrun <= 1'b0;
      end
    end else begin
      audio_sd  <= 1'b1;
      word_done <= 1'b0;

      if (tick) begin
        count   <= '0;
        pdm_clk <= ~pdm_clk;
      end else begin
        count <= count + CW'(1);
      end

      if (accept) begin
        hold      <= data_i;
        hold_full <= 1'b1;
      end

      // accept needs hold empty and a load needs hold full, so they never collide.
      if (bit_event) begin
        if (bits_left != '0) begin
          pdm_data  <= shifter[WORD_LENGTH-1];
          shifter   <= shifter << 1;
          bits_left <= bits_left - BW'(1);
          word_done <= (bits_left == BW'(1));
        end else if (hold_full) begin
          pdm_data  <= hold[WORD_LENGTH-1];
          shifter   <= hold << 1;
          bits_left <= LAST_BIT;
          hold_full <= 1'b0;
          started   <= 1'b1;
          word_done <= (WORD_LENGTH == 1);
        end else begin
          pdm_data   <= idle_phase;
          idle_phase <= ~idle_phase;
        end
      end

      if (starve && started) begin
        underrun <= 1'b1;
      end else if (clear_i) begin
        underrun <= 1'b0;
      end
    end
  end

  assign pdm_clk_o   = pdm_clk;
  assign pdm_data_o  = pdm_data;
  assign word_done_o = word_done;
  assign underrun_o  = underrun;
  assign audio_sd_o  = audio_sd;

endmodule

// File: tb/tb_pdm_serializer.sv
// Self-checking bench for pdm_serializer: expected bits are queued as words are accepted
// and compared against pdm_data_o at every rising edge of pdm_clk_o.
module tb_pdm_serializer;

  logic        clock_i = 1'b0;
  logic        reset_n_i;
  logic        enable_i;
  logic [15:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic        word_done_o;
  logic        underrun_o;
  logic        clear_i;
  logic        pdm_clk_o;
  logic        pdm_data_o;
  logic        audio_sd_o;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_rise = 0;
  int   period = 0;
  int   wd_count = 0;
  bit   exp_q[$];

  pdm_serializer dut (
    .clock_i     (clock_i),
    .reset_n_i   (reset_n_i),
    .enable_i    (enable_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .word_done_o (word_done_o),
    .underrun_o  (underrun_o),
    .clear_i     (clear_i),
    .pdm_clk_o   (pdm_clk_o),
    .pdm_data_o  (pdm_data_o),
    .audio_sd_o  (audio_sd_o)
  );

  always #5 clock_i = ~clock_i;

  initial begin
    forever begin
      @(posedge clock_i);
      cyc = cyc + 1;
    end
  end

  // Scoreboard consumer: each rising bit-clock edge pops one expected bit.
  initial begin
    bit clk_prev;
    bit exp_bit;
    clk_prev = 1'b0;
    forever begin
      @(negedge clock_i);
      if (pdm_clk_o === 1'b1 && !clk_prev) begin
        period    = cyc - last_rise;
        last_rise = cyc;
        if (exp_q.size() > 0) begin
          exp_bit = exp_q.pop_front();
          checks  = checks + 1;
          if (pdm_data_o !== exp_bit) begin
            errors = errors + 1;
            $display("FAIL pdm_bit at cycle %0d: got %b expected %b", cyc, pdm_data_o, exp_bit);
          end else begin
            $display("bit ok at cycle %0d: %b", cyc, pdm_data_o);
          end
        end
      end
      clk_prev = (pdm_clk_o === 1'b1);
      if (word_done_o === 1'b1) wd_count = wd_count + 1;
    end
  end

  task automatic start_stream();
    @(posedge clock_i); #1;
    enable_i = 1'b0; valid_i = 1'b0; clear_i = 1'b1;
    @(posedge clock_i); #1;
    clear_i = 1'b0;
    @(posedge clock_i); #1;
    exp_q.delete();
    wd_count = 0;
    enable_i = 1'b1;
    exp_q.push_back(1'b0); // first rising edge precedes any bit event
  endtask

  task automatic send_word(input logic [15:0] w, output bit ok);
    ok = 1'b0;
    data_i = w;
    valid_i = 1'b1;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clock_i);
      if (ready_o === 1'b1) begin
        @(posedge clock_i); #1;
        ok = 1'b1;
        for (int b = 15; b >= 0; b--) exp_q.push_back(w[b]);
      end
    end
    valid_i = 1'b0;
    $display("send word %h accepted=%0d", w, ok);
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock_i); #1;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; enable_i = 1'b0; valid_i = 1'b0; clear_i = 1'b0; data_i = '0;
    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    checks = checks + 1;
    if ({pdm_clk_o, pdm_data_o, word_done_o, underrun_o, audio_sd_o, ready_o} !== 6'b0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs: got %b expected 000000",
               {pdm_clk_o, pdm_data_o, word_done_o, underrun_o, audio_sd_o, ready_o});
    end
    @(posedge clock_i); #1;
    reset_n_i = 1'b1;
    $display("reset checked");
  endtask

  task automatic test_basic();
    bit ok;
    start_stream();
    send_word(16'hA5C3, ok);
    checks = checks + 1;
    if (!ok) begin errors = errors + 1; $display("FAIL basic_accept: got timeout expected accept"); end
    @(negedge clock_i);
    checks = checks + 1;
    if (ready_o !== 1'b0) begin errors = errors + 1; $display("FAIL basic_ready_full: got %b expected 0", ready_o); end
    repeat (98) @(posedge clock_i);
    @(negedge clock_i);
    checks = checks + 1;
    if ({ready_o, pdm_data_o} !== 2'b00) begin
      errors = errors + 1;
      $display("FAIL basic_pre_load: got ready=%b data=%b expected 0 0", ready_o, pdm_data_o);
    end
    @(posedge clock_i);
    @(negedge clock_i);
    checks = checks + 1;
    if ({ready_o, pdm_data_o} !== 2'b11) begin
      errors = errors + 1;
      $display("FAIL basic_post_load: got ready=%b data=%b expected 1 1", ready_o, pdm_data_o);
    end
    wait_drain(4000, ok);
    checks = checks + 1;
    if (!ok) begin errors = errors + 1; $display("FAIL basic_drain: got timeout expected drained"); end
    checks = checks + 1;
    if (period != 100) begin errors = errors + 1; $display("FAIL basic_period: got %0d expected 100", period); end
    checks = checks + 1;
    if (wd_count != 1) begin errors = errors + 1; $display("FAIL basic_word_done: got %0d expected 1", wd_count); end
    $display("basic word A5C3 done, period=%0d word_done=%0d", period, wd_count);
  endtask

  task automatic test_back_to_back();
    bit ok;
    start_stream();
    send_word(16'hFFFF, ok);
    checks = checks + 1;
    if (!ok) begin errors = errors + 1; $display("FAIL b2b_accept0: got timeout expected accept"); end
    send_word(16'h0000, ok);
    checks = checks + 1;
    if (!ok) begin errors = errors + 1; $display("FAIL b2b_accept1: got timeout expected accept"); end
    @(negedge clock_i);
    checks = checks + 1;
    if (ready_o !== 1'b0) begin errors = errors + 1; $display("FAIL b2b_ready_full: got %b expected 0", ready_o); end
    wait_drain(6000, ok);
    checks = checks + 1;
    if (!ok) begin errors = errors + 1; $display("FAIL b2b_drain: got timeout expected drained"); end
    checks = checks + 1;
    if (underrun_o !== 1'b0) begin errors = errors + 1; $display("FAIL b2b_underrun: got %b expected 0", underrun_o); end
    $display("back-to-back FFFF/0000 done, underrun=%b", underrun_o);
  endtask

  task automatic test_underrun();
    bit ok;
    start_stream();
    send_word(16'h8001, ok);
    checks = checks + 1;
    if (!ok) begin errors = errors + 1; $display("FAIL underrun_accept: got timeout expected accept"); end
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    wait_drain(4000, ok);
    checks = checks + 1;
    if (!ok) begin errors = errors + 1; $display("FAIL underrun_drain: got timeout expected drained"); end
    checks = checks + 1;
    if (underrun_o !== 1'b1) begin errors = errors + 1; $display("FAIL underrun_set: got %b expected 1", underrun_o); end
    @(posedge clock_i); #1; clear_i = 1'b1;
    @(posedge clock_i); #1; clear_i = 1'b0;
    @(negedge clock_i);
    checks = checks + 1;
    if (underrun_o !== 1'b0) begin errors = errors + 1; $display("FAIL underrun_clear: got %b expected 0", underrun_o); end
    exp_q.push_back(1'b0);
    wait_drain(400, ok);
    checks = checks + 1;
    if (!ok) begin errors = errors + 1; $display("FAIL underrun_drain2: got timeout expected drained"); end
    checks = checks + 1;
    if (underrun_o !== 1'b1) begin errors = errors + 1; $display("FAIL underrun_reset: got %b expected 1", underrun_o); end
    $display("underrun 8001 done, underrun=%b", underrun_o);
  endtask

  task automatic test_idle_no_word();
    bit ok;
    start_stream();
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    wait_drain(1000, ok);
    checks = checks + 1;
    if (!ok) begin errors = errors + 1; $display("FAIL idle_drain: got timeout expected drained"); end
    checks = checks + 1;
    if (underrun_o !== 1'b0) begin errors = errors + 1; $display("FAIL idle_underrun: got %b expected 0", underrun_o); end
    $display("idle without word done, underrun=%b", underrun_o);
  endtask

  task automatic test_disable_mid_word();
    bit ok;
    bit reached;
    start_stream();
    send_word(16'h1234, ok);
    checks = checks + 1;
    if (!ok) begin errors = errors + 1; $display("FAIL dis_accept: got timeout expected accept"); end
    reached = 1'b0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      @(negedge clock_i); #1;
      if (exp_q.size() <= 9) reached = 1'b1; // stale bit plus 7 data bits consumed
    end
    checks = checks + 1;
    if (!reached) begin errors = errors + 1; $display("FAIL dis_progress: got timeout expected 7 bits"); end
    @(posedge clock_i); #1;
    enable_i = 1'b0;
    @(posedge clock_i);
    @(negedge clock_i);
    checks = checks + 1;
    if ({pdm_clk_o, pdm_data_o, ready_o} !== 3'b000) begin
      errors = errors + 1;
      $display("FAIL dis_outputs: got clk=%b data=%b ready=%b expected 0 0 0", pdm_clk_o, pdm_data_o, ready_o);
    end
    start_stream();
    send_word(16'h00FF, ok);
    checks = checks + 1;
    if (!ok) begin errors = errors + 1; $display("FAIL dis_accept2: got timeout expected accept"); end
    wait_drain(4000, ok);
    checks = checks + 1;
    if (!ok) begin errors = errors + 1; $display("FAIL dis_drain: got timeout expected drained"); end
    $display("disable mid-word then 00FF done");
  endtask

  task automatic test_async_reset();
    bit ok;
    bit high;
    start_stream();
    send_word(16'hC3C3, ok);
    checks = checks + 1;
    if (!ok) begin errors = errors + 1; $display("FAIL areset_accept: got timeout expected accept"); end
    high = 1'b0;
    for (int i = 0; i < 2000 && !high; i++) begin
      @(negedge clock_i);
      if (pdm_clk_o === 1'b1 && exp_q.size() < 14) high = 1'b1;
    end
    checks = checks + 1;
    if (!high) begin errors = errors + 1; $display("FAIL areset_progress: got timeout expected streaming"); end
    @(posedge clock_i); #2;
    reset_n_i = 1'b0;
    #1;
    checks = checks + 1;
    if ({pdm_clk_o, pdm_data_o, word_done_o, underrun_o, audio_sd_o} !== 5'b0) begin
      errors = errors + 1;
      $display("FAIL areset_outputs: got %b expected 00000",
               {pdm_clk_o, pdm_data_o, word_done_o, underrun_o, audio_sd_o});
    end
    exp_q.delete();
    @(posedge clock_i); #1;
    enable_i = 1'b0;
    reset_n_i = 1'b1;
    $display("async reset mid-stream done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_underrun();
    test_idle_no_word();
    test_disable_mid_word();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pdm_serializer.md
Name: pdm_serializer

Overview:
- PDM transmit path: the counterpart of the microphone deserializer. It accepts WORD_LENGTH-bit words of raw PDM bits over a valid/ready handshake and shifts them out MSB-first, one bit per pdm_clk_o period.
- It generates its own bit clock from the system clock and double-buffers words (holding register plus shift register), so the feeder has a full word time to supply the next word.
- It drives the board's mono audio output path (PDM line plus amplifier shutdown).

Parameters:
- WORD_LENGTH, 16, bits per input word; shifted out MSB-first.
- SYSTEM_FREQUENCY, 100000000, clock_i frequency in Hz.
- SAMPLING_FREQUENCY, 1000000, PDM bit rate in Hz.
- Derived: HALF = (SYSTEM_FREQUENCY/SAMPLING_FREQUENCY)/2. Must be at least 1 (50 at defaults).

Ports:
- clock_i  input  1  system clock; all logic on its rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- enable_i  input  1  synchronous run enable from the Controller.
- data_i  input  WORD_LENGTH  word to transmit.
- valid_i  input  1  data_i valid.
- ready_o  output  1  block can accept a word. Combinational: enable_i & ~hold_full.
- word_done_o  output  1  one-cycle pulse when the last bit of a word is driven.
- underrun_o  output  1  sticky flag: a word boundary found the holding register empty.
- clear_i  input  1  synchronous clear of underrun_o.
- pdm_clk_o  output  1  PDM bit clock, registered.
- pdm_data_o  output  1  PDM bit, registered.
- audio_sd_o  output  1  amplifier enable (1 = on). Registered copy of enable_i.

Behaviour:
- Reset (reset_n_i=0, asynchronous): pdm_clk_o=0, pdm_data_o=0, word_done_o=0, underrun_o=0, audio_sd_o=0, divider counter=0, hold_full=0, bits_left=0, started=0, idle_phase=0.
- enable_i=0 (synchronous): same values as reset, except underrun_o holds its value. ready_o=0. Any buffered word is discarded. audio_sd_o follows enable_i one cycle later.
- Divider: the counter increments every enabled cycle. When counter==HALF-1, it returns to 0 and pdm_clk_o toggles. pdm_clk_o period = 2*HALF cycles, 50% duty, first rising edge HALF cycles after enable.
- Bit event: the cycle in which pdm_clk_o toggles 1->0. pdm_data_o changes only on bit events, so data is stable HALF cycles around each rising edge, where the receiver samples.
- Handshake: a word is accepted on any cycle with valid_i & ready_o. It is written to hold and sets hold_full. data_i is ignored when ready_o=0.
- At each bit event:
  - bits_left>0: pdm_data_o = shifter MSB; shift left; bits_left-1. If bits_left becomes 0, pulse word_done_o.
  - bits_left==0 and hold_full: shifter = hold; pdm_data_o = hold MSB; bits_left = WORD_LENGTH-1; hold_full=0; started=1.
  - bits_left==0 and hold empty: pdm_data_o = idle_phase; idle_phase toggles (a 1010 pattern, i.e. zero audio level). If started, set underrun_o.
- The first bit event after enable has no prior word: bits_left==0, so the first word is loaded then, with no latency beyond the divider.
- Simultaneous handshake accept and bit event in the same cycle: the event sees the registered hold_full (pre-accept). The new word lands in hold and is used at the next boundary.
- WORD_LENGTH=1: every bit event is a word boundary. word_done_o pulses on each load.
- underrun_o: clear_i clears it. If clear_i and a set condition occur in the same cycle, set wins.
- A steady feeder that answers ready_o within 2*HALF*WORD_LENGTH-1 cycles never underruns.

Test Plan:
- Defaults; reset, enable, send 0xA5C3 at once -> pdm_clk_o period 100 cycles. pdm_data_o at successive rising edges is 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. word_done_o pulses once at the 16th bit event. ready_o=1 right after the load.
- Back-to-back 0xFFFF then 0x0000 with valid_i held -> 16 ones then 16 zeros with no gap. ready_o=0 only while hold is full. underrun_o stays 0.
- One word 0x8001, then no more -> after bit 16, pdm_data_o goes 0,1,0,1... and underrun_o=1. Pulse clear_i -> underrun_o=0 on the next cycle, then set again at the next boundary.
- No word before enable -> idle pattern from the first bit event and underrun_o stays 0, because started=0.
- Drop enable_i mid-word (after 7 bits of 0x1234) -> next cycle pdm_clk_o=0, pdm_data_o=0, ready_o=0. Re-enable and send 0x00FF -> output is 0x00FF from bit 0, with no residue of 0x1234.
- Assert reset_n_i low between clock edges during streaming -> all outputs go to reset values immediately, before the next clock edge.
